freq_step_ctrl: RTL and testbench

//  Multi-channel, key-driven frequency setpoint controller for the DDS tone generators.

---
 rtl/freq_step_ctrl_pkg.sv | 41 ++++
 rtl/freq_step_ctrl_if.sv | 13 +
 rtl/freq_step_ctrl_key_repeat.sv | 48 ++++
 rtl/freq_step_ctrl.sv | 132 +++++++++++++
 tb/tb_freq_step_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_step_ctrl_pkg.sv
// Shared types and helpers for the key-driven DDS frequency setpoint controller.
package freq_step_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SEND = 2'd2
    } state_t;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int step_freq(input int f, input logic up, input int stp,
                                     input int fmin, input int fmax, input logic wrap);
        int r;
        if (up) begin
            r = f + stp;
            if (r > fmax) begin
                r = wrap ? fmin : fmax;
            end else begin
                r = r;
            end
        end else begin
            // Compare before subtracting so an unsigned setpoint never underflows.
            if (f < fmin + stp) begin
                r = wrap ? fmax : fmin;
            end else begin
                r = f - stp;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_step_ctrl_if.sv
// Valid/ready config stream carrying one phase increment and its target channel.
interface freq_step_ctrl_if #(
    parameter int PINC_W = 24,
    parameter int CH_W   = 1
);
    logic              tvalid;
    logic              tready;
    logic [PINC_W-1:0] tdata;
    logic [CH_W-1:0]   tdest;

    modport master (output tvalid, output tdata, output tdest, input tready);
    modport slave  (input tvalid, input tdata, input tdest, output tready);
endinterface

// File: rtl/freq_step_ctrl_key_repeat.sv
// Press-edge detector with hold-to-repeat: one pulse on press, then after HOLD_CYC
// cycles held, one pulse every REPEAT_CYC cycles. clr disarms until a fresh press.
module freq_step_ctrl_key_repeat import freq_step_ctrl_pkg::*; #(
    parameter int HOLD_CYC   = 25000000,
    parameter int REPEAT_CYC = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic clr,
    output logic step
);
    localparam int CNT_W = clog2_min1(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(HOLD_CYC - REPEAT_CYC + 1);

    logic             prev_r;
    logic             armed_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_s;

    assign press_s = !key_n && prev_r;
    assign step    = !clr && !key_n && (press_s || (armed_r && (cnt_r == HOLD_C)));

    // Track key history and count held cycles; reload keeps the repeat period exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r  <= 1'b1;
            armed_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            prev_r <= key_n;
            if (clr || key_n) begin
                armed_r <= 1'b0;
                cnt_r   <= {CNT_W{1'b0}};
            end else if (press_s) begin
                armed_r <= 1'b1;
                cnt_r   <= CNT_W'(1);
            end else if (armed_r && (cnt_r == HOLD_C)) begin
                cnt_r <= RELOAD_C;
            end else if (armed_r) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end
endmodule

// File: rtl/freq_step_ctrl.sv
// Per-channel frequency setpoints stepped by keys; changed channels are converted to
// DDS phase increments and streamed out lowest channel first.
module freq_step_ctrl import freq_step_ctrl_pkg::*; #(
    parameter int NUM_CH     = 2,
    parameter int FREQ_W     = 6,
    parameter int FREQ_MIN   = 1,
    parameter int FREQ_MAX   = 30,
    parameter int FREQ_INIT  = 1,
    parameter int FREQ_STEP  = 1,
    parameter int WRAP       = 1,
    parameter int PINC_W     = 24,
    parameter int PINC_MUL   = 41943,
    parameter int PINC_FRAC  = 10,
    parameter int HOLD_CYC   = 25000000,
    parameter int REPEAT_CYC = 5000000,
    localparam int CH_W      = clog2_min1(NUM_CH)
) (
    input  logic                     clk_50m,
    input  logic                     rst,
    input  logic [1:0]               key,
    input  logic [CH_W-1:0]          ch_sel,
    output logic [NUM_CH*FREQ_W-1:0] freq,
    freq_step_ctrl_if.master         cfg
);
    localparam int PROD_W = FREQ_W + PINC_W;

    logic [FREQ_W-1:0] freq_r [NUM_CH];
    logic [NUM_CH-1:0] dirty_r, dirty_s;
    logic [CH_W-1:0]   ch_prev_r, ch_r, pick_ch_s, tdest_r;
    logic [PINC_W-1:0] tdata_r, pinc_s;
    logic              tvalid_r;
    logic              up_s, dn_s, clr_s, ev_s, ch_ok_s, pick_any_s, pick_s, load_s;
    logic [FREQ_W-1:0] f_new_s;
    state_t            state_r, state_n;

    assign ch_ok_s = ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH));
    assign clr_s   = (key == 2'b00) || (ch_sel != ch_prev_r);
    assign ev_s    = (up_s || dn_s) && ch_ok_s;
    assign f_new_s = FREQ_W'(step_freq(int'(freq_r[ch_sel]), up_s, FREQ_STEP,
                                       FREQ_MIN, FREQ_MAX, WRAP != 0));
    assign pinc_s  = PINC_W'((PROD_W'(freq_r[ch_r]) * PROD_W'(PINC_MUL)) >> PINC_FRAC);

    freq_step_ctrl_key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_key_dn (
        .clk(clk_50m), .rst(rst), .key_n(key[0]), .clr(clr_s), .step(dn_s)
    );
    freq_step_ctrl_key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_key_up (
        .clk(clk_50m), .rst(rst), .key_n(key[1]), .clr(clr_s), .step(up_s)
    );

    // Lowest-index dirty channel wins.
    always_comb begin
        pick_any_s = |dirty_r;
        pick_ch_s  = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            pick_ch_s = dirty_r[i] ? CH_W'(i) : pick_ch_s;
        end
    end

    // A new event re-sets dirty after the pick clears it, so the newest value goes out last.
    always_comb begin
        dirty_s = (dirty_r & ~(pick_s ? (NUM_CH'(1) << pick_ch_s) : {NUM_CH{1'b0}}))
                | (ev_s ? (NUM_CH'(1) << ch_sel) : {NUM_CH{1'b0}});
    end

    // FSM state register.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic.
    always_comb begin
        case (state_r)
            S_IDLE:  state_n = pick_any_s ? S_CALC : S_IDLE;
            S_CALC:  state_n = S_SEND;
            S_SEND:  state_n = cfg.tready ? S_IDLE : S_SEND;
            default: state_n = S_IDLE;
        endcase
    end

    // FSM datapath strobes.
    always_comb begin
        pick_s = 1'b0;
        load_s = 1'b0;
        case (state_r)
            S_IDLE:  pick_s = pick_any_s;
            S_CALC:  load_s = 1'b1;
            S_SEND:  pick_s = 1'b0;
            default: pick_s = 1'b0;
        endcase
    end

    // Setpoints, dirty vector and the registered config beat.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                freq_r[i] <= FREQ_W'(FREQ_INIT);
            end
            dirty_r   <= {NUM_CH{1'b1}};
            ch_prev_r <= {CH_W{1'b0}};
            ch_r      <= {CH_W{1'b0}};
            tdata_r   <= {PINC_W{1'b0}};
            tdest_r   <= {CH_W{1'b0}};
            tvalid_r  <= 1'b0;
        end else begin
            ch_prev_r <= ch_sel;
            if (ev_s) begin
                freq_r[ch_sel] <= f_new_s;
            end
            dirty_r <= dirty_s;
            if (pick_s) begin
                ch_r <= pick_ch_s;
            end
            if (load_s) begin
                tdata_r <= pinc_s;
                tdest_r <= ch_r;
            end
            tvalid_r <= (state_n == S_SEND);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_freq
        assign freq[c*FREQ_W +: FREQ_W] = freq_r[c];
    end

    assign cfg.tvalid = tvalid_r;
    assign cfg.tdata  = tdata_r;
    assign cfg.tdest  = tdest_r;
endmodule

// File: tb/tb_freq_step_ctrl.sv
// Bench for freq_step_ctrl: directed table, hand-written corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_freq_step_ctrl;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  key;
    logic [0:0]  ch_sel;
    logic [11:0] freq_a, freq_b;

    freq_step_ctrl_if #(.PINC_W(24), .CH_W(1)) cfg_a ();
    freq_step_ctrl_if #(.PINC_W(24), .CH_W(1)) cfg_b ();

    freq_step_ctrl #(.WRAP(1), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut_a (
        .clk_50m(clk), .rst(rst), .key(key), .ch_sel(ch_sel), .freq(freq_a), .cfg(cfg_a)
    );
    freq_step_ctrl #(.WRAP(0), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut_b (
        .clk_50m(clk), .rst(rst), .key(key), .ch_sel(ch_sel), .freq(freq_b), .cfg(cfg_b)
    );

    always #10 clk = ~clk;

    typedef struct { int dest; int data; } beat_t;
    typedef struct {
        logic [1:0] k; logic c; logic r; int n;
        int ef0; int ef1; int enew; int elast; int edest;
    } vec_t;

    beat_t acc_q[$];
    beat_t accb_q[$];
    vec_t  tbl[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Behavioural model state
    int m_freq[2];
    bit m_dirty[2];
    bit m_valid;
    int m_tdata, m_tdest, m_phase, m_ch, m_chprev, t;
    bit m_armed[2], m_prev[2];
    int m_press_t[2];

    function automatic int pinc(input int f);
        longint p;
        p = longint'(f) * 64'd41943;
        return int'((p / 1024) % 64'd16777216);
    endfunction

    function automatic int stepf(input int f, input bit up);
        if (up) return (f + 1 > 30) ? 1 : f + 1;
        return (f - 1 < 1) ? 30 : f - 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_edge(input logic [1:0] k, input logic c, input logic r, input logic s_rst);
        int  ev_dir;
        bit  clr, press, ev;
        int  d;
        if (s_rst) begin
            m_freq = '{1, 1};
            m_dirty = '{1'b1, 1'b1};
            m_valid = 1'b0; m_tdata = 0; m_tdest = 0; m_phase = 0; m_ch = 0;
            m_armed = '{1'b0, 1'b0}; m_prev = '{1'b1, 1'b1}; m_chprev = 0;
            t++;
            return;
        end
        clr = (k == 2'b00) || (int'(c) != m_chprev);
        ev_dir = 0;
        for (int kk = 0; kk < 2; kk++) begin
            press = !k[kk] && m_prev[kk];
            ev = 1'b0;
            if (!clr && !k[kk]) begin
                if (press) ev = 1'b1;
                else if (m_armed[kk]) begin
                    d = t - m_press_t[kk];
                    ev = (d >= HOLD) && ((d - HOLD) % REP == 0);
                end
            end
            if (ev) ev_dir = (kk == 1) ? 1 : -1;
            if (clr || k[kk]) m_armed[kk] = 1'b0;
            else if (press) begin m_armed[kk] = 1'b1; m_press_t[kk] = t; end
            m_prev[kk] = k[kk];
        end
        case (m_phase)
            0: begin
                if (m_dirty[0]) begin m_dirty[0] = 1'b0; m_ch = 0; m_phase = 1; end
                else if (m_dirty[1]) begin m_dirty[1] = 1'b0; m_ch = 1; m_phase = 1; end
            end
            1: begin
                m_tdata = pinc(m_freq[m_ch]); m_tdest = m_ch; m_valid = 1'b1; m_phase = 2;
            end
            default: begin
                if (r) begin m_valid = 1'b0; m_phase = 0; end
            end
        endcase
        if (ev_dir != 0) begin
            m_freq[c] = stepf(m_freq[c], ev_dir > 0);
            m_dirty[c] = 1'b1;
        end
        m_chprev = int'(c);
        t++;
    endtask

    // One clock: drive inputs, log accepted beats, advance model, check after the edge.
    task automatic apply(input logic [1:0] k, input logic c, input logic r, input logic s_rst);
        logic [11:0] mf;
        key = k; ch_sel = c; rst = s_rst;
        cfg_a.tready = r; cfg_b.tready = r;
        if (cfg_a.tvalid === 1'b1 && r && !s_rst)
            acc_q.push_back('{int'(cfg_a.tdest), int'(cfg_a.tdata)});
        if (cfg_b.tvalid === 1'b1 && r && !s_rst)
            accb_q.push_back('{int'(cfg_b.tdest), int'(cfg_b.tdata)});
        model_edge(k, c, r, s_rst);
        @(posedge clk);
        @(negedge clk);
        mf = {6'(m_freq[1]), 6'(m_freq[0])};
        chk("freq", 64'(freq_a), 64'(mf));
        chk("tvalid", 64'(cfg_a.tvalid), 64'(m_valid));
        chk("tdata", 64'(cfg_a.tdata), 64'(m_tdata));
        chk("tdest", 64'(cfg_a.tdest), 64'(m_tdest));
    endtask

    task automatic chk_beat(input string name, input int idx, input int dest, input int data);
        if (idx >= acc_q.size()) begin
            chk({name, " present"}, 64'(acc_q.size()), 64'(idx + 1));
        end else begin
            chk({name, " dest"}, 64'(acc_q[idx].dest), 64'(dest));
            chk({name, " data"}, 64'(acc_q[idx].data), 64'(data));
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        int base;
        for (int i = lo; i <= hi; i++) begin
            base = acc_q.size();
            repeat (tbl[i].n) apply(tbl[i].k, tbl[i].c, tbl[i].r, 1'b0);
            chk($sformatf("row%0d f0", i), 64'(freq_a[5:0]), 64'(tbl[i].ef0));
            chk($sformatf("row%0d f1", i), 64'(freq_a[11:6]), 64'(tbl[i].ef1));
            if (tbl[i].enew >= 0)
                chk($sformatf("row%0d new beats", i), 64'(acc_q.size() - base), 64'(tbl[i].enew));
            if (tbl[i].elast >= 0)
                chk_beat($sformatf("row%0d last", i), acc_q.size() - 1, tbl[i].edest, tbl[i].elast);
        end
    endtask

    initial begin
        int base;
        logic [1:0] rk;
        logic       rc;
        // key, ch, tready, cycles, f0, f1, new beats, last data, last dest
        tbl.push_back('{2'b11, 1'b0, 1'b1,  8,  1, 1,  2,   40, 1});
        tbl.push_back('{2'b10, 1'b0, 1'b1,  1, 30, 1,  0,   -1, 0});
        tbl.push_back('{2'b11, 1'b0, 1'b1,  6, 30, 1,  1, 1228, 0});
        tbl.push_back('{2'b01, 1'b0, 1'b1,  1,  1, 1,  0,   -1, 0});
        tbl.push_back('{2'b11, 1'b0, 1'b1,  6,  1, 1,  1,   40, 0});
        tbl.push_back('{2'b01, 1'b0, 1'b1, 46,  8, 1, -1,   -1, 0});
        tbl.push_back('{2'b11, 1'b0, 1'b1,  8,  8, 1, -1,  327, 0});
        tbl.push_back('{2'b11, 1'b1, 1'b1,  1,  8, 1,  0,   -1, 0});
        tbl.push_back('{2'b01, 1'b1, 1'b1,  1,  8, 2,  0,   -1, 0});
        tbl.push_back('{2'b11, 1'b1, 1'b1,  6,  8, 2,  1,   81, 1});
        tbl.push_back('{2'b00, 1'b1, 1'b1, 30,  8, 2,  0,   -1, 0});
        tbl.push_back('{2'b01, 1'b1, 1'b1, 30,  8, 2,  0,   -1, 0});
        tbl.push_back('{2'b11, 1'b1, 1'b1,  3,  8, 2,  0,   -1, 0});
        tbl.push_back('{2'b11, 1'b0, 1'b1,  1,  8, 2,  0,   -1, 0});
        tbl.push_back('{2'b01, 1'b0, 1'b1, 22, 10, 2, -1,   -1, 0});
        tbl.push_back('{2'b01, 1'b1, 1'b1, 30, 10, 2, -1,  409, 0});
        tbl.push_back('{2'b01, 1'b1, 1'b1, 20, 10, 2,  0,   -1, 0});
        tbl.push_back('{2'b11, 1'b0, 1'b1,  4, 10, 2,  0,   -1, 0});
        tbl.push_back('{2'b00, 1'b0, 1'b1, 10, 10, 2,  0,   -1, 0});
        tbl.push_back('{2'b11, 1'b0, 1'b1,  4, 10, 2,  0,   -1, 0});

        t = 0;
        key = 2'b11; ch_sel = 1'b0; rst = 1'b1;
        cfg_a.tready = 1'b1; cfg_b.tready = 1'b1;
        @(negedge clk);
        apply(2'b11, 1'b0, 1'b1, 1'b1);
        apply(2'b11, 1'b0, 1'b1, 1'b1);
        chk("reset freq", 64'(freq_a), 64'(12'h041));
        chk("reset tvalid", 64'(cfg_a.tvalid), 64'd0);
        chk("reset tdata", 64'(cfg_a.tdata), 64'd0);
        chk("reset tdest", 64'(cfg_a.tdest), 64'd0);

        run_rows(0, 2);
        chk("sat freq", 64'(freq_b), 64'(12'h041));
        chk("sat beats", 64'(accb_q.size()), 64'd3);
        if (accb_q.size() > 0) begin
            chk("sat last dest", 64'(accb_q[accb_q.size()-1].dest), 64'd0);
            chk("sat last data", 64'(accb_q[accb_q.size()-1].data), 64'd40);
        end
        run_rows(3, tbl.size() - 1);

        // Backpressure: beat in flight holds while both channels are stepped.
        base = acc_q.size();
        repeat (2) apply(2'b11, 1'b0, 1'b0, 1'b0);
        apply(2'b01, 1'b0, 1'b0, 1'b0);
        repeat (3) apply(2'b11, 1'b0, 1'b0, 1'b0);
        chk("bp tvalid", 64'(cfg_a.tvalid), 64'd1);
        apply(2'b01, 1'b0, 1'b0, 1'b0);
        apply(2'b11, 1'b0, 1'b0, 1'b0);
        apply(2'b11, 1'b1, 1'b0, 1'b0);
        apply(2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(2'b11, 1'b1, 1'b0, 1'b0);
            chk("bp hold valid", 64'(cfg_a.tvalid), 64'd1);
            chk("bp hold data", 64'(cfg_a.tdata), 64'(pinc(11)));
            chk("bp hold dest", 64'(cfg_a.tdest), 64'd0);
        end
        chk("bp no accept", 64'(acc_q.size() - base), 64'd0);
        repeat (12) apply(2'b11, 1'b1, 1'b1, 1'b0);
        chk("bp beats", 64'(acc_q.size() - base), 64'd3);
        chk_beat("bp beat0", base, 0, pinc(11));
        chk_beat("bp beat1", base + 1, 0, pinc(12));
        chk_beat("bp beat2", base + 2, 1, pinc(3));

        // Reset while a beat is stalled.
        apply(2'b11, 1'b0, 1'b0, 1'b0);
        apply(2'b01, 1'b0, 1'b0, 1'b0);
        repeat (3) apply(2'b11, 1'b0, 1'b0, 1'b0);
        chk("rst pre tvalid", 64'(cfg_a.tvalid), 64'd1);
        apply(2'b11, 1'b0, 1'b0, 1'b1);
        chk("rst tvalid", 64'(cfg_a.tvalid), 64'd0);
        chk("rst freq", 64'(freq_a), 64'(12'h041));
        base = acc_q.size();
        repeat (8) apply(2'b11, 1'b0, 1'b1, 1'b0);
        chk("rst sweep beats", 64'(acc_q.size() - base), 64'd2);
        chk_beat("rst sweep0", base, 0, 40);
        chk_beat("rst sweep1", base + 1, 1, 40);

        // Randomized run against the model.
        rk = 2'b11; rc = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: rk = 2'b11;
                    3:       rk = 2'b10;
                    4:       rk = 2'b01;
                    default: rk = 2'b00;
                endcase
            end
            if ($urandom_range(0, 59) == 0) rc = ~rc;
            apply(rk, rc, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
